// File: rtl/lfsr_checker_param.sv
// lfsr_checker_param: self-synchronising PRBS/LFSR checker.
// Seeds its expected word from the received stream, hunts for LOCK_CNT
// consecutive matches, then flywheels the sequence and counts errors until
// UNLOCK_CNT consecutive mismatches drop it back to hunting.
module lfsr_checker_param #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  POLY       = 8'h8D,
    parameter bit                ZERO_INS   = 1'b1,
    parameter int unsigned       LOCK_CNT   = 5,
    parameter int unsigned       UNLOCK_CNT = 4,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_resync,
    input  logic             i_clear,
    output logic             o_lock,
    output logic             o_match,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_count,
    output logic [WIDTH-1:0] o_expected
);

    typedef enum logic [1:0] {ST_SEED, ST_HUNT, ST_LOCK} state_t;

    // Counters compare against "last" values so an 8-bit count covers 1..255.
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    // One Galois step; the zero-insertion term lets the sequence visit all-zero.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        logic             fb;
        logic [WIDTH-1:0] n;
        fb   = s[WIDTH-1] ^ (ZERO_INS && (s[WIDTH-2:0] == '0));
        n    = '0;
        n[0] = fb;
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = s[i-1] ^ (POLY[i] & fb);
        end
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   exp_q, exp_d;
    logic [7:0]         match_cnt_q, match_cnt_d;
    logic [7:0]         miss_cnt_q, miss_cnt_d;
    logic               match_q, match_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_inc;
    logic               hit;

    assign hit = (i_data == exp_q);

    // State register.
    always_ff @(posedge clk) begin
        if (i_reset) state_q <= ST_SEED;
        else         state_q <= state_d;
    end

    // Next-state: seed -> hunt -> lock, back to hunt on a run of misses.
    always_comb begin
        state_d = state_q;
        if (i_resync) begin
            state_d = ST_SEED;
        end else if (i_valid) begin
            case (state_q)
                ST_SEED: state_d = ST_HUNT;
                ST_HUNT: if (hit && match_cnt_q == LOCK_LAST) state_d = ST_LOCK;
                ST_LOCK: if (!hit && miss_cnt_q == UNLOCK_LAST) state_d = ST_HUNT;
                default: state_d = ST_SEED;
            endcase
        end
    end

    // Datapath next values: expected word, run counters, per-word flags.
    always_comb begin
        exp_d       = exp_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        match_d     = 1'b0;
        err_d       = 1'b0;
        err_inc     = 1'b0;
        if (i_resync) begin
            // Word in this cycle is dropped; error count is deliberately kept.
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else if (i_valid) begin
            case (state_q)
                ST_SEED: begin
                    exp_d       = lfsr_next(i_data);
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
                ST_HUNT: begin
                    if (hit) begin
                        match_d     = 1'b1;
                        exp_d       = lfsr_next(exp_q);
                        match_cnt_d = (match_cnt_q == LOCK_LAST) ? 8'd0 : match_cnt_q + 8'd1;
                    end else begin
                        // Unlocked mismatches just reseed; they are not errors.
                        exp_d       = lfsr_next(i_data);
                        match_cnt_d = '0;
                    end
                end
                ST_LOCK: begin
                    exp_d = lfsr_next(exp_q);
                    if (hit) begin
                        match_d    = 1'b1;
                        miss_cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        if (miss_cnt_q == UNLOCK_LAST) begin
                            exp_d       = lfsr_next(i_data);
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating error counter; clear beats a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_clear)                        err_cnt_d = '0;
        else if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            exp_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            match_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            exp_q       <= exp_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            match_q     <= match_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Outputs are all straight from flops.
    always_comb begin
        o_lock      = (state_q == ST_LOCK);
        o_match     = match_q;
        o_err       = err_q;
        o_err_count = err_cnt_q;
        o_expected  = exp_q;
    end

endmodule

// File: tb/tb_lfsr_checker_param.sv
// Scoreboard bench for lfsr_checker_param. Stimulus pushes hand-computed
// expected outputs into a queue; a negedge monitor pops and compares.
// Reference sequence (POLY 8'h8D, zero insertion):
// 01 02 04 08 10 20 40 80 00 8D 97 A3 CB 1B 36 6C D8 3D ...
module tb_lfsr_checker_param;

    typedef struct {
        logic        m;
        logic        e;
        logic        l;
        logic [15:0] c;
        logic [7:0]  x;
        string       n;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        a_reset = 1'b1, a_valid = 1'b0, a_resync = 1'b0, a_clear = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic        a_lock, a_match, a_err;
    logic [15:0] a_cnt;
    logic [7:0]  a_exp;

    // DUT B: LOCK_CNT=1, UNLOCK_CNT=8, 2-bit counter for saturation
    logic        b_reset = 1'b1, b_valid = 1'b0, b_resync = 1'b0, b_clear = 1'b0;
    logic [7:0]  b_data = 8'h00;
    logic        b_lock, b_match, b_err;
    logic [1:0]  b_cnt;
    logic [7:0]  b_exp;

    lfsr_checker_param dut_a (
        .clk(clk), .i_reset(a_reset), .i_valid(a_valid), .i_data(a_data),
        .i_resync(a_resync), .i_clear(a_clear), .o_lock(a_lock), .o_match(a_match),
        .o_err(a_err), .o_err_count(a_cnt), .o_expected(a_exp)
    );

    lfsr_checker_param #(.LOCK_CNT(1), .UNLOCK_CNT(8), .CNT_W(2)) dut_b (
        .clk(clk), .i_reset(b_reset), .i_valid(b_valid), .i_data(b_data),
        .i_resync(b_resync), .i_clear(b_clear), .o_lock(b_lock), .o_match(b_match),
        .o_err(b_err), .o_err_count(b_cnt), .o_expected(b_exp)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle on A, queue the response expected after that edge.
    task automatic cyc_a(input logic rst, input logic v, input logic [7:0] d,
                         input logic rs, input logic cl,
                         input logic em, input logic ee, input logic el,
                         input logic [15:0] ec, input logic [7:0] ex, input string nm);
        exp_t t;
        a_reset = rst; a_valid = v; a_data = d; a_resync = rs; a_clear = cl;
        @(posedge clk);
        #1;
        t.m = em; t.e = ee; t.l = el; t.c = ec; t.x = ex; t.n = nm;
        qa.push_back(t);
    endtask

    task automatic cyc_b(input logic rst, input logic v, input logic [7:0] d,
                         input logic cl,
                         input logic em, input logic ee, input logic el,
                         input logic [15:0] ec, input logic [7:0] ex, input string nm);
        exp_t t;
        b_reset = rst; b_valid = v; b_data = d; b_resync = 1'b0; b_clear = cl;
        @(posedge clk);
        #1;
        t.m = em; t.e = ee; t.l = el; t.c = ec; t.x = ex; t.n = nm;
        qb.push_back(t);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        exp_t t;
        if (qa.size() > 0) begin
            t = qa.pop_front();
            checks++;
            if ({a_match, a_err, a_lock, a_cnt, a_exp} !== {t.m, t.e, t.l, t.c, t.x}) begin
                errors++;
                $display("FAIL A.%s: got m=%0b e=%0b l=%0b cnt=%0d exp=%h, want m=%0b e=%0b l=%0b cnt=%0d exp=%h",
                         t.n, a_match, a_err, a_lock, a_cnt, a_exp, t.m, t.e, t.l, t.c, t.x);
            end
        end
        if (qb.size() > 0) begin
            t = qb.pop_front();
            checks++;
            if ({b_match, b_err, b_lock, 14'd0, b_cnt, b_exp} !== {t.m, t.e, t.l, t.c, t.x}) begin
                errors++;
                $display("FAIL B.%s: got m=%0b e=%0b l=%0b cnt=%0d exp=%h, want m=%0b e=%0b l=%0b cnt=%0d exp=%h",
                         t.n, b_match, b_err, b_lock, b_cnt, b_exp, t.m, t.e, t.l, t.c, t.x);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset
        cyc_a(1, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h00, "reset");
        // case 1: seed and lock
        cyc_a(0, 1, 8'h01, 0, 0,  0, 0, 0, 0, 8'h02, "c1_seed");
        cyc_a(0, 1, 8'h02, 0, 0,  1, 0, 0, 0, 8'h04, "c1_w2");
        cyc_a(0, 1, 8'h04, 0, 0,  1, 0, 0, 0, 8'h08, "c1_w3");
        cyc_a(0, 1, 8'h08, 0, 0,  1, 0, 0, 0, 8'h10, "c1_w4");
        cyc_a(0, 1, 8'h10, 0, 0,  1, 0, 0, 0, 8'h20, "c1_w5");
        cyc_a(0, 1, 8'h20, 0, 0,  1, 0, 1, 0, 8'h40, "c1_lock");
        // case 2: zero-insertion wrap
        cyc_a(0, 1, 8'h40, 0, 0,  1, 0, 1, 0, 8'h80, "c2_40");
        cyc_a(0, 1, 8'h80, 0, 0,  1, 0, 1, 0, 8'h00, "c2_80");
        cyc_a(0, 1, 8'h00, 0, 0,  1, 0, 1, 0, 8'h8D, "c2_00");
        cyc_a(0, 1, 8'h8D, 0, 0,  1, 0, 1, 0, 8'h97, "c2_8d");
        // case 3: three corrupted words, then resume
        cyc_a(0, 1, 8'h68, 0, 0,  0, 1, 1, 1, 8'hA3, "c3_err1");
        cyc_a(0, 1, 8'h5C, 0, 0,  0, 1, 1, 2, 8'hCB, "c3_err2");
        cyc_a(0, 1, 8'h34, 0, 0,  0, 1, 1, 3, 8'h1B, "c3_err3");
        cyc_a(0, 1, 8'h1B, 0, 0,  1, 0, 1, 3, 8'h36, "c3_resume");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 1, 3, 8'h36, "c3_idle");
        // case 4: four misses unlock, then relock from successor of 4th
        cyc_a(0, 1, 8'hC9, 0, 0,  0, 1, 1, 4, 8'h6C, "c4_miss1");
        cyc_a(0, 1, 8'h93, 0, 0,  0, 1, 1, 5, 8'hD8, "c4_miss2");
        cyc_a(0, 1, 8'h27, 0, 0,  0, 1, 1, 6, 8'h3D, "c4_miss3");
        cyc_a(0, 1, 8'h01, 0, 0,  0, 1, 0, 7, 8'h02, "c4_unlock");
        cyc_a(0, 1, 8'h02, 0, 0,  1, 0, 0, 7, 8'h04, "c4_re1");
        cyc_a(0, 1, 8'h04, 0, 0,  1, 0, 0, 7, 8'h08, "c4_re2");
        cyc_a(0, 1, 8'h08, 0, 0,  1, 0, 0, 7, 8'h10, "c4_re3");
        cyc_a(0, 1, 8'h10, 0, 0,  1, 0, 0, 7, 8'h20, "c4_re4");
        cyc_a(0, 1, 8'h20, 0, 0,  1, 0, 1, 7, 8'h40, "c4_relock");
        // case 5: reset overrides valid/clear, then gapped stream
        cyc_a(1, 1, 8'h99, 0, 1,  0, 0, 0, 0, 8'h00, "c5_reset");
        cyc_a(0, 1, 8'h01, 0, 0,  0, 0, 0, 0, 8'h02, "c5_seed");
        cyc_a(0, 0, 8'h55, 0, 0,  0, 0, 0, 0, 8'h02, "c5_gap1");
        cyc_a(0, 1, 8'h02, 0, 0,  1, 0, 0, 0, 8'h04, "c5_w2");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h04, "c5_gap2");
        cyc_a(0, 1, 8'h04, 0, 0,  1, 0, 0, 0, 8'h08, "c5_w3");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h08, "c5_gap3");
        cyc_a(0, 1, 8'h08, 0, 0,  1, 0, 0, 0, 8'h10, "c5_w4");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h10, "c5_gap4");
        cyc_a(0, 1, 8'h10, 0, 0,  1, 0, 0, 0, 8'h20, "c5_w5");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h20, "c5_gap5");
        cyc_a(0, 1, 8'h20, 0, 0,  1, 0, 1, 0, 8'h40, "c5_lock");
        cyc_a(0, 0, 8'h00, 0, 0,  0, 0, 1, 0, 8'h40, "c5_gap6");
        // case 6: clear vs increment, resync with valid, hunt reseed
        cyc_a(0, 1, 8'h00, 0, 0,  0, 1, 1, 1, 8'h80, "c6_err");
        cyc_a(0, 1, 8'h00, 0, 1,  0, 1, 1, 0, 8'h00, "c6_clear_err");
        cyc_a(0, 1, 8'hFF, 0, 0,  0, 1, 1, 1, 8'h8D, "c6_err2");
        cyc_a(0, 1, 8'h12, 1, 0,  0, 0, 0, 1, 8'h8D, "c6_resync");
        cyc_a(0, 1, 8'h55, 0, 0,  0, 0, 0, 1, 8'hAA, "c6_seed");
        cyc_a(0, 1, 8'h13, 0, 0,  0, 0, 0, 1, 8'h26, "c6_hunt_miss");
        cyc_a(0, 1, 8'h26, 0, 0,  1, 0, 0, 1, 8'h4C, "c6_hunt_hit");
        cyc_a(0, 0, 8'h00, 0, 1,  0, 0, 0, 0, 8'h4C, "c6_clear");
        a_clear = 1'b0;
        // DUT B: lock on first match, saturate 2-bit counter
        cyc_b(1, 0, 8'h00, 0,  0, 0, 0, 0, 8'h00, "reset");
        cyc_b(0, 1, 8'h01, 0,  0, 0, 0, 0, 8'h02, "seed");
        cyc_b(0, 1, 8'h02, 0,  1, 0, 1, 0, 8'h04, "lock1");
        cyc_b(0, 1, 8'h00, 0,  0, 1, 1, 1, 8'h08, "err1");
        cyc_b(0, 1, 8'h00, 0,  0, 1, 1, 2, 8'h10, "err2");
        cyc_b(0, 1, 8'h00, 0,  0, 1, 1, 3, 8'h20, "err3");
        cyc_b(0, 1, 8'h00, 0,  0, 1, 1, 3, 8'h40, "sat4");
        cyc_b(0, 1, 8'h00, 0,  0, 1, 1, 3, 8'h80, "sat5");
        cyc_b(0, 1, 8'h80, 0,  1, 0, 1, 3, 8'h00, "match");
        cyc_b(0, 0, 8'h00, 1,  0, 0, 1, 0, 8'h00, "clear");
        b_clear = 1'b0;
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
        @(posedge clk);
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker_param.md
Name: lfsr_checker_param

Overview:
Parametrised, self-synchronising PRBS/LFSR checker. It is the successor to the fixed 8-bit checker, with configurable width, polynomial, zero-insertion mode, and lock/unlock thresholds. It seeds from the received stream, flywheels the expected sequence once locked, and reports per-word match/error plus a saturating error count. It sits at the receive end of the LFSR loopback path, after the generator.

Parameters:
WIDTH, 8, word/LFSR width in bits (min 3)
POLY, 8'h8D, Galois tap mask; bit i=1 XORs feedback into bit i (bit 0 always takes feedback)
ZERO_INS, 1, 1 = feedback also XORed with (s[WIDTH-2:0]==0), giving a 2^WIDTH-state sequence including all-zero
LOCK_CNT, 5, consecutive matches in HUNT required to lock (1..255)
UNLOCK_CNT, 4, consecutive mismatches in LOCK required to drop lock (1..255)
CNT_W, 16, error counter width

Ports:
clk  in  1  clock
i_reset  in  1  synchronous reset, active high
i_valid  in  1  i_data is valid this cycle
i_data  in  WIDTH  received LFSR word
i_resync  in  1  force return to SEED state
i_clear  in  1  clear o_err_count
o_lock  out  1  checker locked
o_match  out  1  registered: last valid word matched
o_err  out  1  registered: last valid word mismatched while locked
o_err_count  out  CNT_W  saturating count of locked mismatches
o_expected  out  WIDTH  current expected word

Behaviour:
- Clock and reset: single clock clk. i_reset is synchronous, active-high, and sampled on the rising edge of clk.
- next(s) definition: fb = s[W-1] ^ (ZERO_INS & (s[W-2:0]==0)); next[0] = fb; next[i] = s[i-1] ^ (POLY[i] & fb) for i ≥ 1.
- Reset: state=SEED; exp=0; match_cnt=0; miss_cnt=0; o_lock=0; o_match=0; o_err=0; o_err_count=0. i_reset overrides all other inputs.
- i_valid=0: no state, counter, or exp change. o_match and o_err go to 0 (single-cycle pulses).
- SEED state, on i_valid: exp ← next(i_data); go to HUNT; no match/err reported.
- HUNT state, on i_valid:
  - i_data==exp: o_match=1; exp ← next(exp); match_cnt++. If match_cnt+1==LOCK_CNT → LOCK, o_lock=1, match_cnt=0.
  - mismatch: reseed exp ← next(i_data); match_cnt=0; o_err=0 (unlocked errors are not counted).
- LOCK state, on i_valid:
  - exp ← next(exp) always (flywheel; never reseeds while locked).
  - match: o_match=1; miss_cnt=0.
  - mismatch: o_err=1; o_err_count++ (saturates at all-ones); miss_cnt++. If miss_cnt+1==UNLOCK_CNT → HUNT, o_lock=0, exp ← next(i_data), miss_cnt=0, match_cnt=0.
- Latency:
  - o_lock rises on the clock edge that consumes the LOCK_CNT-th consecutive matching word after seeding.
  - o_lock falls on the edge consuming the UNLOCK_CNT-th consecutive mismatch.
  - o_match and o_err are valid one cycle after the word is sampled.
- i_resync (no i_reset): next state=SEED; o_lock=0; counters cleared except o_err_count. If i_valid is asserted in the same cycle, the word is discarded.
- i_clear: o_err_count ← 0. Clear wins over a same-cycle increment.
- LOCK_CNT=1: lock on the first matching word after seed. UNLOCK_CNT=1: a single mismatch drops lock.
- Saturation: o_err_count holds at 2^CNT_W−1 until i_clear or i_reset.
- o_expected = exp (registered, no combinational path from i_data).

Test Plan:
(All cases use defaults: WIDTH=8, POLY=8'h8D, ZERO_INS=1.)
1. Reset, then feed 0x01,0x02,0x04,0x08,0x10,0x20 on consecutive valids → o_match high for words 2–6; o_lock=1 after the 6th word; o_err_count=0.
2. Zero-insertion wrap: locked stream continues 0x40,0x80,0x00,0x8D → all match; o_expected passes through 0x00 and 0x8D; o_lock stays 1.
3. Locked, inject 3 corrupted words (XOR 0xFF), then resume the correct sequence → o_err pulses 3 times; o_err_count=3; o_lock stays 1; miss_cnt resets on the next match.
4. Locked, inject 4 consecutive wrong words → o_lock=0 after the 4th; then 5 correct words continuing from the 4th wrong word's successor → relock.
5. Valid gaps: same stream as case 1 with i_valid toggled 1/0 → identical lock point counted in valid words; o_match pulses only after valid cycles.
6. Assert i_resync while locked with i_valid=1 → word ignored; state SEED; o_lock=0; o_err_count retained. Then i_clear with a simultaneous mismatch → o_err_count=0. Force o_err_count to saturation (CNT_W=2): 5 locked errors with UNLOCK_CNT=8 → count holds at 3.
